axi4_stream_to_axi4: RTL and testbench

Packet writer: accepts one AXI4-Stream packet per `wr_stb_i` command and stores it to memory through AXI4 INCR write bursts starting at a beat-aligned address. It is the write-side counterpart of the frame buffer's memory-to-stream reader and sits between the video/packet input pipeline and the AXI4 memory interconnect. The read channels are tied off.

---
 rtl/axi4_stream_to_axi4_if.sv | 86 ++++++++
 rtl/axi4_stream_to_axi4.sv | 166 ++++++++++++++++
 tb/tb_axi4_stream_to_axi4.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_to_axi4_if.sv
// axi4_stream_to_axi4_if: AXI4-Stream and AXI4 bus interfaces used by the packet writer.
interface axi4_stream_if #(parameter int DATA_WIDTH = 64);
  logic [DATA_WIDTH-1:0] tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master(output tdata, tkeep, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tlast, tvalid, output tready);
endinterface

interface axi4_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 1,
  parameter int AWUSER_WIDTH = 1,
  parameter int WUSER_WIDTH = 1,
  parameter int ARUSER_WIDTH = 1
);
  logic [ID_WIDTH-1:0] awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic [3:0] awqos;
  logic [3:0] awregion;
  logic [AWUSER_WIDTH-1:0] awuser;
  logic awvalid;
  logic awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wlast;
  logic [WUSER_WIDTH-1:0] wuser;
  logic wvalid;
  logic wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [3:0] arqos;
  logic [3:0] arregion;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic arvalid;
  logic arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master(
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input wready,
    input bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input arready,
    input rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave(
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input rready
  );
endinterface

// File: rtl/axi4_stream_to_axi4.sv
// axi4_stream_to_axi4: writes one AXI4-Stream packet to memory as 4 KB-safe AXI4 INCR bursts.
// Optional AXI4_STREAM_TO_AXI4_BRESP_CHECK_EN flags non-OKAY BRESP in err_o[2].
module axi4_stream_to_axi4 #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 1,
  parameter int AWUSER_WIDTH = 1,
  parameter int WUSER_WIDTH = 1,
  parameter int ARUSER_WIDTH = 1,
  parameter int MAX_PKT_SIZE_B = 2048,
  parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic wr_stb_i,
  output logic busy_o,
  output logic done_o,
  output logic [2:0] err_o,
  axi4_stream_if.slave pkt_i,
  axi4_if.master mem_o
);
  localparam int DB = DATA_WIDTH / 8;
  localparam int AL = $clog2(DB);
  localparam int PW = MAX_PKT_SIZE_WIDTH;
  localparam int CW = PW + 14;
  localparam logic [2:0] IDLE_S = 3'd0;
  localparam logic [2:0] CALC_BURST_S = 3'd1;
  localparam logic [2:0] ADDR_S = 3'd2;
  localparam logic [2:0] DATA_S = 3'd3;
  localparam logic [2:0] RESP_S = 3'd4;
  localparam logic [2:0] FLUSH_S = 3'd5;
`ifdef AXI4_STREAM_TO_AXI4_BRESP_CHECK_EN
  localparam bit BRESP_CHK = 1'b1;
`else
  localparam bit BRESP_CHK = 1'b0;
`endif
  logic [2:0] st;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [PW-1:0] words_left;
  logic [8:0] burst_left;
  logic early;
  logic last_tl;
  logic awvalid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [PW:0] words;
  logic [CW-1:0] b4k;
  logic [CW-1:0] bmin;
  logic [CW-1:0] blen;
  logic w_hs;
  always_comb begin
    words = ({1'b0, pkt_size_i} + (PW+1)'(DB - 1)) >> AL;
    b4k = (CW'(13'h1000) - CW'(cur_addr[11:0])) >> AL;
    bmin = (CW'(words_left) < b4k) ? CW'(words_left) : b4k;
    blen = (bmin > CW'(256)) ? CW'(256) : bmin;
  end
  // After an early tlast the stream is no longer consumed; the rest of the packet is written as empty-strobe beats.
  assign mem_o.wvalid = (st == DATA_S) && (early || pkt_i.tvalid);
  assign pkt_i.tready = ((st == DATA_S) && !early && mem_o.wready) || (st == FLUSH_S);
  assign mem_o.wdata = pkt_i.tdata;
  assign mem_o.wstrb = early ? '0 : pkt_i.tkeep;
  assign mem_o.wlast = (st == DATA_S) && (burst_left == 9'd1);
  assign mem_o.wuser = '0;
  assign w_hs = mem_o.wvalid && mem_o.wready;
  assign mem_o.awid = '0;
  assign mem_o.awaddr = awaddr;
  assign mem_o.awlen = awlen;
  assign mem_o.awsize = 3'(AL);
  assign mem_o.awburst = 2'b01;
  assign mem_o.awlock = 1'b0;
  assign mem_o.awcache = '0;
  assign mem_o.awprot = '0;
  assign mem_o.awqos = '0;
  assign mem_o.awregion = '0;
  assign mem_o.awuser = '0;
  assign mem_o.awvalid = awvalid;
  assign mem_o.bready = (st == RESP_S);
  assign mem_o.arid = '0;
  assign mem_o.araddr = '0;
  assign mem_o.arlen = '0;
  assign mem_o.arsize = '0;
  assign mem_o.arburst = '0;
  assign mem_o.arlock = 1'b0;
  assign mem_o.arcache = '0;
  assign mem_o.arprot = '0;
  assign mem_o.arqos = '0;
  assign mem_o.arregion = '0;
  assign mem_o.aruser = '0;
  assign mem_o.arvalid = 1'b0;
  assign mem_o.rready = 1'b1;
  assign busy_o = (st != IDLE_S);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st <= IDLE_S;
      cur_addr <= '0;
      words_left <= '0;
      burst_left <= '0;
      early <= 1'b0;
      last_tl <= 1'b0;
      awvalid <= 1'b0;
      awaddr <= '0;
      awlen <= '0;
      done_o <= 1'b0;
      err_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (st)
        IDLE_S:
          if (wr_stb_i && pkt_size_i != '0) begin
            cur_addr <= {addr_i[ADDR_WIDTH-1:AL], {AL{1'b0}}};
            words_left <= PW'(words);
            err_o <= '0;
            early <= 1'b0;
            last_tl <= 1'b0;
            st <= CALC_BURST_S;
          end
        CALC_BURST_S: begin
          awaddr <= cur_addr;
          awlen <= 8'(blen - CW'(1));
          burst_left <= 9'(blen);
          awvalid <= 1'b1;
          st <= ADDR_S;
        end
        ADDR_S:
          if (mem_o.awready) begin
            awvalid <= 1'b0;
            cur_addr <= cur_addr + (ADDR_WIDTH'(burst_left) << AL);
            st <= DATA_S;
          end
        DATA_S:
          if (w_hs) begin
            burst_left <= burst_left - 9'd1;
            words_left <= words_left - PW'(1);
            if (!early) begin
              last_tl <= pkt_i.tlast;
              if (pkt_i.tlast && words_left != PW'(1)) begin
                early <= 1'b1;
                err_o[0] <= 1'b1;
              end
            end
            if (mem_o.wlast) st <= RESP_S;
          end
        RESP_S:
          if (mem_o.bvalid) begin
            if (BRESP_CHK && mem_o.bresp != 2'b00) err_o[2] <= 1'b1;
            if (words_left != '0) st <= CALC_BURST_S;
            else if (last_tl || early) begin
              st <= IDLE_S;
              done_o <= 1'b1;
            end else begin
              st <= FLUSH_S;
              err_o[1] <= 1'b1;
            end
          end
        FLUSH_S:
          if (pkt_i.tvalid && pkt_i.tlast) begin
            st <= IDLE_S;
            done_o <= 1'b1;
          end
        default: st <= IDLE_S;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_stream_to_axi4.sv
// tb_axi4_stream_to_axi4: randomized scoreboard bench for the stream-to-AXI4 packet writer.
module tb_axi4_stream_to_axi4;
  localparam int DW = 64;
  localparam int PS = 4096;
  localparam int PSW = $clog2(PS) + 1;
  typedef struct packed { logic [31:0] a; logic [7:0] l; } aw_t;
  typedef struct packed { logic [63:0] d; logic [7:0] s; logic l; } w_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [PSW-1:0] pkt_size_i = '0;
  logic [31:0] addr_i = '0;
  logic wr_stb_i = 1'b0;
  logic busy_o, done_o;
  logic [2:0] err_o;
  int total = 0;
  int bad = 0;
  aw_t exp_aw[$];
  w_t exp_w[$];
  logic [63:0] sdata[$];
  logic [7:0] skeep[$];
  logic [63:0] mem_act [int unsigned];
  logic [63:0] mem_exp [int unsigned];
  int bpend = 0;
  bit bresp_err = 1'b0;
  bit aw_open = 1'b0;
  logic [31:0] waddr = '0;
  axi4_stream_if #(.DATA_WIDTH(DW)) pkt();
  axi4_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(32)) mem();
  axi4_stream_to_axi4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .MAX_PKT_SIZE_B(PS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pkt_size_i(pkt_size_i), .addr_i(addr_i), .wr_stb_i(wr_stb_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .pkt_i(pkt), .mem_o(mem)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] bm(input logic [7:0] s);
    for (int i = 0; i < 8; i++) bm[i*8 +: 8] = {8{s[i]}};
  endfunction
  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    merge = (o & ~bm(s)) | (n & bm(s));
  endfunction
  // Reference: bursts split at 256 beats and 4 KB pages; stream beats past an early tlast become empty strobes.
  task automatic model(input int sz, input logic [31:0] a, input int L, input bit be, output logic [2:0] e);
    int words, left, b, r, idx, n;
    logic [31:0] cur, base;
    int bl[$];
    w_t w;
    logic [63:0] old;
    int unsigned k;
    words = (sz + 7) / 8;
    base = a & 32'hFFFF_FFF8;
    cur = base;
    left = words;
    while (left > 0) begin
      b = (left < 256) ? left : 256;
      r = int'((32'd4096 - (cur % 32'd4096)) / 32'd8);
      if (r < b) b = r;
      exp_aw.push_back('{cur, 8'(b - 1)});
      bl.push_back(b);
      cur += 32'(b * 8);
      left -= b;
    end
    sdata.delete();
    skeep.delete();
    for (int i = 0; i < L; i++) begin
      n = sz - i * 8;
      if (n > 8 || n < 1) n = 8;
      sdata.push_back({$urandom, $urandom});
      skeep.push_back(8'((1 << n) - 1));
    end
    idx = 0;
    foreach (bl[j]) begin
      for (int q = 0; q < bl[j]; q++) begin
        w.d = (idx < L) ? sdata[idx] : 64'h0;
        w.s = (idx < L) ? skeep[idx] : 8'h0;
        w.l = (q == bl[j] - 1);
        exp_w.push_back(w);
        k = (base >> 3) + 32'(idx);
        old = mem_exp.exists(k) ? mem_exp[k] : 64'h0;
        mem_exp[k] = merge(old, w.d, w.s);
        idx++;
      end
    end
    e = (L < words) ? 3'b001 : (L > words) ? 3'b010 : 3'b000;
`ifdef AXI4_STREAM_TO_AXI4_BRESP_CHECK_EN
    if (be) e[2] = 1'b1;
`endif
    bresp_err = be;
  endtask
  task automatic drive();
    bit hs;
    int t;
    @(posedge clk_i); #1;
    for (int i = 0; i < sdata.size(); i++) begin
      while ($urandom_range(0, 3) == 0) begin @(posedge clk_i); #1; end
      pkt.tvalid = 1'b1;
      pkt.tdata = sdata[i];
      pkt.tkeep = skeep[i];
      pkt.tlast = (i == sdata.size() - 1);
      t = 0;
      do begin
        @(negedge clk_i);
        hs = pkt.tready;
        @(posedge clk_i); #1;
        t++;
      end while (!hs && t < 3000);
      pkt.tvalid = 1'b0;
      pkt.tlast = 1'b0;
      if (!hs) begin
        chk("beat_accept", 64'(hs), 64'd1);
        break;
      end
    end
  endtask
  task automatic wait_done(output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (n < 20000 && !got) begin
      @(posedge clk_i); #1;
      wr_stb_i = (n == 5);
      n++;
      @(negedge clk_i);
      got = done_o;
    end
    wr_stb_i = 1'b0;
  endtask
  task automatic run_pkt(input int sz, input logic [31:0] a, input int L, input bit be);
    logic [2:0] e;
    bit got;
    int words;
    int unsigned k;
    logic [63:0] act;
    words = (sz + 7) / 8;
    model(sz, a, L, be, e);
    @(posedge clk_i); #1;
    pkt_size_i = PSW'(sz);
    addr_i = a;
    wr_stb_i = 1'b1;
    @(negedge clk_i);
    chk("busy_before", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;
    wr_stb_i = 1'b0;
    pkt_size_i = PSW'($urandom_range(1, 600));
    addr_i = $urandom;
    @(negedge clk_i);
    chk("busy_calc", 64'(busy_o), 64'd1);
    chk("aw_calc", 64'(mem.awvalid), 64'd0);
    @(negedge clk_i);
    chk("aw_latency", 64'(mem.awvalid), 64'd1);
    fork
      drive();
      wait_done(got);
    join
    chk("done_seen", 64'(got), 64'd1);
    chk("err", 64'(err_o), 64'(e));
    chk("aw_left", 64'(exp_aw.size()), 64'd0);
    chk("w_left", 64'(exp_w.size()), 64'd0);
    @(negedge clk_i);
    chk("done_pulse", 64'(done_o), 64'd0);
    chk("idle", 64'(busy_o), 64'd0);
    chk("err_hold", 64'(err_o), 64'(e));
    for (int i = 0; i < words; i++) begin
      k = ((a & 32'hFFFF_FFF8) >> 3) + 32'(i);
      act = mem_act.exists(k) ? mem_act[k] : 64'h0;
      chk("mem", act, mem_exp.exists(k) ? mem_exp[k] : 64'h0);
    end
  endtask
  initial begin : monitor
    aw_t ea;
    w_t ew;
    int unsigned k;
    logic [63:0] old;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (mem.awvalid && mem.awready) begin
          if (exp_aw.size() == 0) chk("aw_extra", 64'(mem.awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            ea = exp_aw.pop_front();
            chk("awaddr", 64'(mem.awaddr), 64'(ea.a));
            chk("awlen", 64'(mem.awlen), 64'(ea.l));
            chk("awsize", 64'(mem.awsize), 64'd3);
            chk("awburst", 64'(mem.awburst), 64'd1);
          end
          waddr = mem.awaddr;
          aw_open = 1'b1;
        end
        if (mem.wvalid && mem.wready) begin
          chk("w_after_aw", 64'(aw_open), 64'd1);
          if (exp_w.size() == 0) chk("w_extra", 64'(mem.wstrb), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            ew = exp_w.pop_front();
            chk("wstrb", 64'(mem.wstrb), 64'(ew.s));
            chk("wlast", 64'(mem.wlast), 64'(ew.l));
            chk("wdata", (mem.wdata ^ ew.d) & bm(ew.s), 64'h0);
            if (ew.s == 8'h0) chk("pad_tready", 64'(pkt.tready), 64'd0);
          end
          k = waddr >> 3;
          old = mem_act.exists(k) ? mem_act[k] : 64'h0;
          mem_act[k] = merge(old, mem.wdata, mem.wstrb);
          waddr += 32'd8;
          if (mem.wlast) begin
            aw_open = 1'b0;
            bpend++;
          end
        end
      end
    end
  end
  initial begin : slave
    bit bh;
    mem.awready = 1'b0;
    mem.wready = 1'b0;
    mem.bvalid = 1'b0;
    mem.bresp = 2'b00;
    mem.bid = '0;
    mem.arready = 1'b0;
    mem.rid = '0;
    mem.rdata = '0;
    mem.rresp = '0;
    mem.rlast = 1'b0;
    mem.rvalid = 1'b0;
    forever begin
      @(negedge clk_i);
      bh = mem.bvalid && mem.bready;
      @(posedge clk_i); #1;
      mem.awready = 1'($urandom_range(0, 1));
      mem.wready = ($urandom_range(0, 3) != 0);
      if (bh) begin
        mem.bvalid = 1'b0;
        bpend--;
      end
      if (!mem.bvalid && bpend > 0 && $urandom_range(0, 2) == 0) begin
        mem.bvalid = 1'b1;
        mem.bresp = bresp_err ? 2'b10 : 2'b00;
      end
    end
  end
  initial begin : stim
    logic [2:0] e;
    int sz, words, L, n;
    pkt.tvalid = 1'b0;
    pkt.tlast = 1'b0;
    pkt.tdata = '0;
    pkt.tkeep = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_awvalid", 64'(mem.awvalid), 64'd0);
    chk("rst_wvalid", 64'(mem.wvalid), 64'd0);
    chk("rst_bready", 64'(mem.bready), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_awaddr", 64'(mem.awaddr), 64'd0);
    chk("rst_awlen", 64'(mem.awlen), 64'd0);
    chk("rst_tready", 64'(pkt.tready), 64'd0);
    chk("arvalid", 64'(mem.arvalid), 64'd0);
    chk("rready", 64'(mem.rready), 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    pkt_size_i = '0;
    wr_stb_i = 1'b1;
    @(posedge clk_i); #1;
    wr_stb_i = 1'b0;
    @(negedge clk_i);
    chk("zero_size_ignored", 64'(busy_o), 64'd0);
    run_pkt(100, 32'h1003, 13, 1'b0);
    run_pkt(4096, 32'h0, 512, 1'b0);
    run_pkt(64, 32'hFF0, 8, 1'b0);
    run_pkt(64, 32'h3000, 4, 1'b0);
    run_pkt(16, 32'h4000, 5, 1'b0);
    run_pkt(32, 32'h5008, 4, 1'b1);
    for (int r = 0; r < 15; r++) begin
      sz = $urandom_range(1, 600);
      words = (sz + 7) / 8;
      L = ($urandom_range(0, 9) < 6) ? words : $urandom_range(1, words + 3);
      run_pkt(sz, $urandom_range(0, 32'h7FFF), L, $urandom_range(0, 7) == 0);
    end
    model(512, 32'h2000, 64, 1'b0, e);
    @(posedge clk_i); #1;
    pkt_size_i = PSW'(512);
    addr_i = 32'h2000;
    wr_stb_i = 1'b1;
    @(posedge clk_i); #1;
    wr_stb_i = 1'b0;
    fork
      drive();
    join_none
    n = 0;
    while (n < 3000 && !mem.wvalid) begin
      @(negedge clk_i);
      n++;
    end
    chk("wvalid_seen", 64'(mem.wvalid), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_awvalid", 64'(mem.awvalid), 64'd0);
    chk("arst_wvalid", 64'(mem.wvalid), 64'd0);
    chk("arst_wlast", 64'(mem.wlast), 64'd0);
    chk("arst_bready", 64'(mem.bready), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    chk("arst_awaddr", 64'(mem.awaddr), 64'd0);
    chk("arst_awlen", 64'(mem.awlen), 64'd0);
    chk("arst_tready", 64'(pkt.tready), 64'd0);
    disable fork;
    pkt.tvalid = 1'b0;
    pkt.tlast = 1'b0;
    exp_aw.delete();
    exp_w.delete();
    mem_act.delete();
    mem_exp.delete();
    bpend = 0;
    aw_open = 1'b0;
    mem.bvalid = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    run_pkt(200, 32'h6FF8, 25, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
